// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RV32I ALU issue/writeback front end.
// Holds opcode, funct3 and funct7 constants, the issue FSM state type and
// the instruction decode helper used by alu_issue.
package alu_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB  = 3'b000;
    localparam logic [2:0] F3_SLL      = 3'b001;
    localparam logic [2:0] F3_SLT      = 3'b010;
    localparam logic [2:0] F3_SLTU     = 3'b011;
    localparam logic [2:0] F3_XOR      = 3'b100;
    localparam logic [2:0] F3_SRL_SRA  = 3'b101;
    localparam logic [2:0] F3_OR       = 3'b110;
    localparam logic [2:0] F3_AND      = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Decoded view of one instruction word.
    typedef struct packed {
        logic        legal;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
    } dec_t;

    // Decode an OP / OP-IMM word into the ALU controls and operand source.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.legal   = 1'b0;
        d.funct3  = instr[14:12];
        d.funct7  = FUNCT7_BASE;
        d.rd      = instr[11:7];
        d.use_imm = 1'b0;
        d.imm     = 32'd0;
        case (instr[6:0])
            OPC_OP: begin
                d.funct7 = instr[31:25];
                if (instr[31:25] == FUNCT7_BASE) begin
                    d.legal = 1'b1;
                end else if ((instr[31:25] == FUNCT7_ALT) &&
                             ((instr[14:12] == F3_ADD_SUB) ||
                              (instr[14:12] == F3_SRL_SRA))) begin
                    d.legal = 1'b1;
                end else begin
                    d.legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                // funct7 stays BASE by default so ADDI with bit 30 set is
                // never mistaken for SUB by the ALU.
                d.use_imm = 1'b1;
                d.imm     = {{20{instr[31]}}, instr[31:20]};
                case (instr[14:12])
                    F3_SLL: begin
                        d.legal = (instr[31:25] == FUNCT7_BASE);
                    end
                    F3_SRL_SRA: begin
                        d.legal  = (instr[31:25] == FUNCT7_BASE) ||
                                   (instr[31:25] == FUNCT7_ALT);
                        d.funct7 = instr[31:25];
                        d.imm    = {27'd0, instr[24:20]};
                    end
                    default: begin
                        d.legal = 1'b1;
                    end
                endcase
            end
            default: begin
                d.legal = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the instruction handshake, the ALU port set and the
// retire/illegal reporting of the issue front end.
//   master: issue block view (drives ready, ALU controls, retire, illegal)
//   slave : environment view (drives instr handshake and ALU result)
interface alu_issue_if;
    import alu_pkg::*;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        alu_enable;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_data_1;
    logic [31:0] alu_data_2;
    logic [31:0] alu_data_out;
    logic        illegal;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;

    modport master (
        input  instr_valid, instr, alu_data_out,
        output instr_ready, alu_enable, alu_funct3, alu_funct7,
               alu_data_1, alu_data_2, illegal,
               retire_valid, retire_rd, retire_data
    );

    modport slave (
        output instr_valid, instr, alu_data_out,
        input  instr_ready, alu_enable, alu_funct3, alu_funct7,
               alu_data_1, alu_data_2, illegal,
               retire_valid, retire_rd, retire_data
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 32x32 integer register file.
// Ports: clock, reset_n (async active-low, clears all entries),
//   three combinational reads (rs1, rs2, dbg), one write port (we/waddr/wdata).
// x0 always reads 0 and writes to it are dropped.
module alu_issue_regfile (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [32];

    // Storage: cleared on reset, written on we for non-zero addresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem_q[waddr] <= wdata;
        end else begin
            mem_q[waddr] <= mem_q[waddr];
        end
    end

    // Read ports with x0 forced to zero.
    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? 32'd0 : mem_q[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? 32'd0 : mem_q[rs2_addr];
        dbg_data = (dbg_addr == 5'd0) ? 32'd0 : mem_q[dbg_addr];
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback front end for the RV32I ALU.
// Ports: clock, reset_n (async active-low), bus (alu_issue_if.master:
//   instruction handshake, ALU controls/operands/result, illegal and retire
//   reporting), dbg_addr/dbg_data (combinational register read).
// Decodes OP / OP-IMM words, reads operands, holds the ALU enabled for
// ALU_LATENCY cycles, then writes the sampled result back to rd.
module alu_issue
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_issue_if.master bus,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] data2_q, data2_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;
    logic        retire_valid_q, retire_valid_d;
    logic [4:0]  retire_rd_q, retire_rd_d;
    logic [31:0] retire_data_q, retire_data_d;

    dec_t        dec_s;
    logic        accept_s;
    logic        last_s;
    logic        ready_s;
    logic        enable_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic        we_s;

    alu_issue_regfile u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .rs1_addr (bus.instr[19:15]),
        .rs1_data (rs1_val_s),
        .rs2_addr (bus.instr[24:20]),
        .rs2_data (rs2_val_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (we_s),
        .waddr    (rd_q),
        .wdata    (bus.alu_data_out)
    );

    // Handshake qualification and end-of-execution detection. armed_q keeps
    // a handshake on the reset release edge from being taken.
    always_comb begin
        dec_s    = decode(bus.instr);
        accept_s = bus.instr_valid && ready_s && armed_q;
        last_s   = (state_q == EXEC) && (cnt_q == 4'd1);
        we_s     = last_s;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s && dec_s.legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready_s  = 1'b0;
        enable_s = 1'b0;
        case (state_q)
            IDLE: begin
                ready_s  = 1'b1;
                enable_s = 1'b0;
            end
            EXEC: begin
                ready_s  = 1'b0;
                enable_s = 1'b1;
            end
            default: begin
                ready_s  = 1'b0;
                enable_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand capture, latency counter, pulses, retire.
    always_comb begin
        armed_d        = 1'b1;
        cnt_d          = cnt_q;
        funct3_d       = funct3_q;
        funct7_d       = funct7_q;
        data1_d        = data1_q;
        data2_d        = data2_q;
        rd_d           = rd_q;
        illegal_d      = accept_s && !dec_s.legal;
        retire_valid_d = 1'b0;
        retire_rd_d    = retire_rd_q;
        retire_data_d  = retire_data_q;
        if (accept_s && dec_s.legal) begin
            cnt_d    = 4'(ALU_LATENCY);
            funct3_d = dec_s.funct3;
            funct7_d = dec_s.funct7;
            data1_d  = rs1_val_s;
            data2_d  = dec_s.use_imm ? dec_s.imm : rs2_val_s;
            rd_d     = dec_s.rd;
        end else if (state_q == EXEC) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (last_s) begin
            retire_valid_d = 1'b1;
            retire_rd_d    = rd_q;
            retire_data_d  = bus.alu_data_out;
        end else begin
            retire_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q        <= 1'b0;
            cnt_q          <= 4'd0;
            funct3_q       <= 3'd0;
            funct7_q       <= 7'd0;
            data1_q        <= 32'd0;
            data2_q        <= 32'd0;
            rd_q           <= 5'd0;
            illegal_q      <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_rd_q    <= 5'd0;
            retire_data_q  <= 32'd0;
        end else begin
            armed_q        <= armed_d;
            cnt_q          <= cnt_d;
            funct3_q       <= funct3_d;
            funct7_q       <= funct7_d;
            data1_q        <= data1_d;
            data2_q        <= data2_d;
            rd_q           <= rd_d;
            illegal_q      <= illegal_d;
            retire_valid_q <= retire_valid_d;
            retire_rd_q    <= retire_rd_d;
            retire_data_q  <= retire_data_d;
        end
    end

    assign bus.instr_ready  = ready_s;
    assign bus.alu_enable   = enable_s;
    assign bus.alu_funct3   = funct3_q;
    assign bus.alu_funct7   = funct7_q;
    assign bus.alu_data_1   = data1_q;
    assign bus.alu_data_2   = data2_q;
    assign bus.illegal      = illegal_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_rd    = retire_rd_q;
    assign bus.retire_data  = retire_data_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback front end for the RV32I ALU: it decodes OP and OP-IMM instruction words and reads operands from an internal 32x32 register file. It drives the ALU's enable/funct3/funct7/operand ports, waits the ALU latency, then writes the ALU result back to rd. It sits between instruction fetch and the ALU and is the producer and consumer of the ALU's port set.

## Interface

- ALU_LATENCY, 1, cycles from first enabled edge to valid alu_data_out; legal range 1..15
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word offered
- instr_ready  out  1  block can accept; equals (state == IDLE)
- instr  in  32  RV32I instruction word
- alu_enable  out  1  ALU enable
- alu_funct3  out  3  ALU operation select
- alu_funct7  out  7  ALU operation type
- alu_data_1  out  32  operand 1 (rs1 value)
- alu_data_2  out  32  operand 2 (rs2 value or immediate)
- alu_data_out  in  32  ALU result
- illegal  out  1  one-cycle pulse: accepted word not executable
- retire_valid  out  1  one-cycle pulse: result written
- retire_rd  out  5  destination of retired instruction
- retire_data  out  32  value written
- dbg_addr  in  5  debug register read address
- dbg_data  out  32  combinational register read; x0 reads 0

## Operation

- Accept on the edge with instr_valid && instr_ready; decode the accepted word in that cycle.
- OP (opcode 0110011): funct7 0000000 is legal for every funct3. funct7 0100000 is legal only for funct3 000 (SUB) and 101 (SRA). data_2 = x[rs2].
- OP-IMM (opcode 0010011):
  - Default: data_2 = sign-extended instr[31:20]; funct7 driven 0000000, so ADDI never selects SUB.
  - funct3 001: instr[31:25] must be 0000000.
  - funct3 101: instr[31:25] must be 0000000 or 0100000 and is driven to funct7; data_2 = zero-extended shamt instr[24:20].
- Any other opcode or funct7 is illegal. illegal pulses in the cycle after accept; state stays IDLE; no ALU enable, no register write.
- FSM:
  - IDLE: ready = 1. On a legal accept, register funct3, funct7, data_1, data_2 and rd, then go to EXEC.
  - EXEC: alu_enable = 1 and operands held stable for ALU_LATENCY cycles; a down-counter tracks the cycles. On the final EXEC edge, sample alu_data_out, write x[rd] when rd != 0, load the retire registers, and go to IDLE.
- x0: reads return 0 and writes are dropped. A retire with rd = 0 is still reported, with retire_data = the ALU value.
- Outside EXEC, the alu_* operand outputs hold their last values; alu_enable = 0.

## Timing

- Legal accept at edge T:
  - alu_enable high for cycles T+1 .. T+ALU_LATENCY.
  - Result sampled at the edge closing cycle T+ALU_LATENCY.
  - retire_valid high in cycle T+ALU_LATENCY+1, with state back in IDLE and ready = 1.
- Register writes complete at the sampling edge. A dependent instruction accepted during the retire cycle reads the new value with no hazard logic.
- Throughput: one instruction per ALU_LATENCY+1 cycles. Illegal words are absorbed at one per cycle.
- Reset (asserted at any time, including mid-EXEC):
  - state = IDLE and all 32 registers = 0.
  - alu_enable, illegal and retire_valid = 0.
  - alu_funct3, alu_funct7, alu_data_1, alu_data_2, retire_rd and retire_data = 0.
  - instr_ready = 1. An in-flight instruction is dropped without retire.
- A handshake coincident with the reset_n release edge is ignored.

## Structure

- Shared package alu_pkg: opcode constants OP/OP_IMM, funct3 codes, funct7 codes FUNCT7_BASE = 0000000 and FUNCT7_ALT = 0100000, FSM state enum {IDLE, EXEC}.
- Sub-module alu_issue_regfile: 32x32 storage, async reset to 0, three combinational read ports (rs1, rs2, dbg), one write port, x0 hardwired to 0.

## Test plan

- ADDI x1,x0,5 (0x00500093), ALU_LATENCY=1, accept at T -> in T+1: alu_enable=1, funct3=000, funct7=0000000, data_1=0, data_2=5; bench ALU returns 5 -> in T+2: retire_valid=1, rd=1, data=5; dbg x1=5.
- With x1=5 and x2=3, SUB x3,x1,x2 (0x402081B3) -> funct7=0100000, data_1=5, data_2=3; ALU returns 2 -> retire rd=3, data=2.
- Operand forms:
  - SRAI x4,x1,3 (0x4030D213) -> funct3=101, funct7=0100000, data_2=3.
  - ADDI x5,x0,-1 (0xFFF00293) -> data_2=0xFFFFFFFF.
- Illegal words:
  - JAL (0x0000006F) -> illegal=1 at T+1, no alu_enable, no retire, ready stays 1.
  - OP with funct7=0100000, funct3=001 (0x40209033) -> illegal=1 at T+1.
- ADDI x0,x0,7 (0x00700013) -> retire rd=0, data=7; dbg x0 = 0.
- ALU_LATENCY=3:
  - ADDI x1,x0,1 then dependent ADDI x1,x1,1 offered in the retire cycle -> accepted immediately with data_1=1, retire x1=2.
  - reset_n pulsed low mid-EXEC -> alu_enable drops immediately, no retire, all registers read 0.
